// File: rtl/mm_pkg.sv
// Shared types and width helpers for the matrix multiplier.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ZLOAD = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } mm_state_e;

    // Accumulator width: full product plus 16 guard bits for the K-term sum.
    function automatic int unsigned acc_width(input int unsigned data_width);
        return 2 * data_width + 16;
    endfunction

endpackage

// File: rtl/mm_pipe_mult.sv
// Signed DATA_WIDTH x DATA_WIDTH multiplier with MUL_LAT register stages.
module mm_pipe_mult #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MUL_LAT    = 1
) (
    input  logic                           clk,
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic signed [2*DATA_WIDTH-1:0] p
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] b_ext;
    logic signed [PROD_WIDTH-1:0] stage [MUL_LAT];

    assign a_ext = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_ext = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};

    // Product enters stage 0, then shifts down the pipe; data needs no reset.
    always_ff @(posedge clk) begin
        stage[0] <= a_ext * b_ext;
        for (int unsigned s = 1; s < MUL_LAT; s++) begin
            stage[s] <= stage[s-1];
        end
    end

    assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/matrix_multiplier_v3.sv
// Sequential Z = (acc ? Z : 0) + X*Y engine over row-major matrices in external RAMs.
module matrix_multiplier_v3 #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned MUL_LAT    = 1,
    parameter int unsigned FRAC_BITS  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  acc_mode,
    input  logic [ADDR_WIDTH-1:0] m_rows,
    input  logic [ADDR_WIDTH-1:0] n_cols,
    input  logic [ADDR_WIDTH-1:0] k_inner,
    input  logic [ADDR_WIDTH-1:0] x_base,
    input  logic [ADDR_WIDTH-1:0] y_base,
    input  logic [ADDR_WIDTH-1:0] z_base,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic [DATA_WIDTH-1:0] y_data,
    input  logic [DATA_WIDTH-1:0] z_rdata,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic [ADDR_WIDTH-1:0] z_addr,
    output logic [DATA_WIDTH-1:0] z_wdata,
    output logic                  z_wen,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    import mm_pkg::*;

    localparam int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH);
    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned PIPE_LAT   = RAM_LAT + MUL_LAT;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    mm_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] m_r, n_r, k_r, y_base_r;
    logic [ADDR_WIDTH-1:0] x_row, y_col, i_cnt, j_cnt, cnt;
    logic                  acc_r;
    logic [PIPE_LAT-1:0]   vld_sr;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [PROD_WIDTH-1:0] prod;

    logic                  zero_dim_c, row_wrap_c, last_elem_c, sat_hit_c;
    logic [ADDR_WIDTH-1:0] x_row_nxt_c, y_col_nxt_c, elem_x_c, elem_y_c;
    logic signed [ACC_WIDTH-1:0] prod_ext_c, zpre_c, acc_sum_c, shifted_c;
    logic [DATA_WIDTH-1:0] sat_c;

    mm_pipe_mult #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_LAT    (MUL_LAT)
    ) u_mult (
        .clk (clk),
        .a   ($signed(x_data)),
        .b   ($signed(y_data)),
        .p   (prod)
    );

    assign zero_dim_c  = (m_rows == '0) || (n_cols == '0) || (k_inner == '0);
    assign row_wrap_c  = (j_cnt == n_r - ADDR_WIDTH'(1));
    assign last_elem_c = row_wrap_c && (i_cnt == m_r - ADDR_WIDTH'(1));
    assign x_row_nxt_c = row_wrap_c ? x_row + k_r : x_row;
    assign y_col_nxt_c = row_wrap_c ? y_base_r : y_col + ADDR_WIDTH'(1);

    assign prod_ext_c = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign zpre_c     = {{(ACC_WIDTH-DATA_WIDTH){z_rdata[DATA_WIDTH-1]}}, z_rdata} <<< FRAC_BITS;
    assign acc_sum_c  = acc + (vld_sr[PIPE_LAT-1] ? prod_ext_c : '0);
    assign shifted_c  = acc_sum_c >>> FRAC_BITS;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; phase lengths are timed by cnt, which restarts on every state change.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_dim_c ? DONE : (acc_mode ? ZLOAD : ISSUE);
            ZLOAD:   if (cnt == ADDR_WIDTH'(RAM_LAT)) state_nxt = ISSUE;
            ISSUE:   if (cnt == k_r - ADDR_WIDTH'(1)) state_nxt = DRAIN;
            DRAIN:   if (cnt == ADDR_WIDTH'(PIPE_LAT - 1)) state_nxt = WRITE;
            WRITE:   state_nxt = last_elem_c ? DONE : (acc_r ? ZLOAD : ISSUE);
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // First X/Y address of the upcoming element, depending on where ISSUE is entered from.
    always_comb begin
        elem_x_c = x_row;
        elem_y_c = y_col;
        if (state == IDLE) begin
            elem_x_c = x_base;
            elem_y_c = y_base;
        end else if (state == WRITE) begin
            elem_x_c = x_row_nxt_c;
            elem_y_c = y_col_nxt_c;
        end
    end

    // Round-to--inf shift result clamped to the signed DATA_WIDTH range.
    always_comb begin
        sat_hit_c = 1'b0;
        sat_c     = shifted_c[DATA_WIDTH-1:0];
        if (shifted_c > SAT_MAX) begin
            sat_hit_c = 1'b1;
            sat_c     = SAT_MAX[DATA_WIDTH-1:0];
        end else if (shifted_c < SAT_MIN) begin
            sat_hit_c = 1'b1;
            sat_c     = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // Status outputs, phase counter, product tagging and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            z_wen  <= 1'b0;
            cnt    <= '0;
            vld_sr <= '0;
            acc    <= '0;
        end else begin
            busy   <= (state_nxt != IDLE);
            done   <= (state_nxt == DONE);
            z_wen  <= (state == DRAIN) && (state_nxt == WRITE);
            cnt    <= (state_nxt == state) ? cnt + ADDR_WIDTH'(1) : '0;
            vld_sr <= {vld_sr[PIPE_LAT-2:0], state == ISSUE};
            if (state == ZLOAD && state_nxt == ISSUE)  acc <= zpre_c;
            else if (state == WRITE || state == IDLE)  acc <= '0;
            else                                       acc <= acc_sum_c;
        end
    end

    // Config capture, element walk and address/result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r      <= '0;
            n_r      <= '0;
            k_r      <= '0;
            acc_r    <= 1'b0;
            y_base_r <= '0;
            x_row    <= '0;
            y_col    <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            x_addr   <= '0;
            y_addr   <= '0;
            z_addr   <= '0;
            z_wdata  <= '0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                m_r      <= m_rows;
                n_r      <= n_cols;
                k_r      <= k_inner;
                acc_r    <= acc_mode;
                y_base_r <= y_base;
                x_row    <= x_base;
                y_col    <= y_base;
                z_addr   <= z_base;
                i_cnt    <= '0;
                j_cnt    <= '0;
                overflow <= 1'b0;
            end
            if (state == DRAIN && state_nxt == WRITE) begin
                z_wdata <= sat_c;
                if (sat_hit_c) overflow <= 1'b1;
            end
            if (state == WRITE) begin
                z_addr <= z_addr + ADDR_WIDTH'(1);
                x_row  <= x_row_nxt_c;
                y_col  <= y_col_nxt_c;
                if (row_wrap_c) begin
                    j_cnt <= '0;
                    i_cnt <= i_cnt + ADDR_WIDTH'(1);
                end else begin
                    j_cnt <= j_cnt + ADDR_WIDTH'(1);
                end
            end
            if (state_nxt == ISSUE) begin
                if (state == ISSUE) begin
                    x_addr <= x_addr + ADDR_WIDTH'(1);
                    y_addr <= y_addr + n_r;
                end else begin
                    x_addr <= elem_x_c;
                    y_addr <= elem_y_c;
                end
            end
        end
    end

endmodule

// File: doc/matrix_multiplier_v3.md
MATRIX_MULTIPLIER_V3 -- requirements
Module: matrix_multiplier_v3

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, signed element width.
REQ-003 SHALL have parameter RAM_LAT, default 1, read latency in cycles from address to data for X/Y/Z RAMs (1..4).
REQ-004 SHALL have parameter MUL_LAT, default 1, multiplier pipeline depth (1..4).
REQ-005 SHALL have parameter FRAC_BITS, default 0, fixed-point fraction bits (0..DATA_WIDTH-1).
REQ-006 SHALL have ports; reset rst, synchronous, active-high; clock clk:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 start  in  1  one-cycle request, sampled only in IDLE
 acc_mode  in  1  0: Z=X*Y; 1: Z=Z+X*Y (sampled with start)
 m_rows, n_cols, k_inner  in  ADDR_WIDTH each  M, N, K (sampled with start)
 x_base, y_base, z_base  in  ADDR_WIDTH each  row-major base addresses (sampled with start)
 x_data, y_data, z_rdata  in  DATA_WIDTH each  RAM read data
 x_addr, y_addr, z_addr  out  ADDR_WIDTH each  RAM addresses
 z_wdata  out  DATA_WIDTH  result element
 z_wen  out  1  one-cycle write strobe
 busy  out  1  high from cycle after accepted start through DONE
 done  out  1  one-cycle completion pulse
 overflow  out  1  sticky saturation flag, cleared on accepted start

Function
REQ-007 SHALL compute Z[i][j] = sat(( (acc_mode ? Z[i][j]<<FRAC_BITS : 0) + sum_k X[i][k]*Y[k][j] ) >>> FRAC_BITS), signed, arithmetic shift truncating toward -inf.
REQ-008 SHALL address x_base+i*K+k, y_base+k*N+j, z_base+i*N+j, all modulo 2^ADDR_WIDTH.
REQ-009 SHALL accumulate in ACC_WIDTH = 2*DATA_WIDTH+16 bits; saturation to DATA_WIDTH signed range SHALL set overflow.
REQ-010 SHALL use FSM IDLE -> (ZLOAD if acc_mode) -> ISSUE -> DRAIN -> WRITE -> next element (ZLOAD/ISSUE) or DONE -> IDLE.
REQ-011 ZLOAD SHALL last RAM_LAT+1 cycles, driving z_addr and capturing z_rdata into the accumulator on its last cycle.
REQ-012 ISSUE SHALL last K cycles, presenting one X/Y address pair per cycle; a valid shift register of depth RAM_LAT+MUL_LAT SHALL tag products.
REQ-013 DRAIN SHALL last RAM_LAT+MUL_LAT cycles; accumulator SHALL add each tagged product on arrival.
REQ-014 WRITE SHALL last 1 cycle with z_wen=1, z_wdata and z_addr valid in the same cycle; accumulator cleared for next element.
REQ-015 Per-element cycles E = K+RAM_LAT+MUL_LAT+1 (+RAM_LAT+1 if acc_mode); done SHALL assert exactly 1+M*N*E cycles after the start cycle.
REQ-016 Element order SHALL be row-major (j inner, i outer).
REQ-017 If M, N or K is zero, SHALL go IDLE -> DONE with no z_wen, done one cycle after start.
REQ-018 start while not IDLE SHALL be ignored; start in DONE cycle SHALL be ignored.
REQ-019 Config inputs changing while busy SHALL not affect the running operation.

Reset
REQ-020 rst SHALL force IDLE and zero x_addr, y_addr, z_addr, z_wdata, z_wen, busy, done, overflow, accumulator and valid pipeline, including mid-operation, with no further z_wen.

Structure
REQ-021 Package mm_pkg SHALL hold the FSM state enum and ACC_WIDTH derivation function.
REQ-022 Sub-module mm_pipe_mult SHALL implement the signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH multiplier with MUL_LAT register stages.

Verification
REQ-023 X=[[1,2,3],[4,5,6]], Y=[[7,8],[9,10],[11,12]], acc_mode=0, RAM_LAT=MUL_LAT=1 -> writes 58,64,139,154 at z_base..z_base+3; done at cycle 1+4*6=25.
REQ-024 Same, acc_mode=1, Z preloaded [1,1,1,1] -> writes 59,65,140,155; done at cycle 1+4*8=33.
REQ-025 1x1x1, X=0x7FFFFFFF, Y=2 -> z_wdata=0x7FFFFFFF, overflow=1; next start clears overflow.
REQ-026 FRAC_BITS=8, X=0x0180 (1.5), Y=0x0200 (2.0), 1x1x1 -> z_wdata=0x0300; X=-1 (0xFFFFFFFF), Y=1 -> 0xFFFFFFFF.
REQ-027 k_inner=0 -> done one cycle after start, zero z_wen; start pulsed while busy -> no restart, done count unchanged.
REQ-028 rst asserted during ISSUE of element 2 -> next cycle busy=0, all outputs 0, no z_wen; fresh start completes correctly.
